// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - multicycle ARM control unit: state sequencing, decode, NZCV flags, condition gating
`timescale 1ns/1ps
module arm_mc_controller #(
   parameter int COND_EN = 1,
   parameter int STATE_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [2:0]  ALUControl
);

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   // Instr holds IR[31:12]; field offsets below are relative to bit 12.
   logic [3:0] cond, cmd, rd;
   logic [1:0] op;
   logic       i_bit, s_bit, u_bit;
   logic       unused_rn;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign i_bit     = Instr[13];
   assign cmd       = Instr[12:9];
   assign u_bit     = Instr[11];
   assign s_bit     = Instr[8];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   logic [2:0] alu_dp;
   logic       dp_arith, dp_cmp, dp_nowrite;

   always_comb begin
      alu_dp     = 3'b000;
      dp_arith   = 1'b0;
      dp_cmp     = 1'b0;
      dp_nowrite = 1'b0;
      case (cmd)
         4'b0100: dp_arith = 1'b1;
         4'b0010: begin alu_dp = 3'b001; dp_arith = 1'b1; end
         4'b0000: alu_dp = 3'b010;
         4'b1100: alu_dp = 3'b011;
         4'b1010: begin alu_dp = 3'b001; dp_arith = 1'b1; dp_cmp = 1'b1; dp_nowrite = 1'b1; end
         default: dp_nowrite = 1'b1;
      endcase
   end

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ok, cond_ex;

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = ~flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = ~flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = ~flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = ~flag_v;
         4'b1000: cond_ok = flag_c & ~flag_z;
         4'b1001: cond_ok = ~flag_c | flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ok = flag_z | (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign cond_ex = (COND_EN != 0) ? cond_ok : 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (op)
               2'b01:   state_d = MEMADR;
               2'b00:   state_d = i_bit ? EXECI : EXECR;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: state_d = s_bit ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
         default: state_d = FETCH;
      endcase
   end

   // Flags see the execute-cycle ALU result; C,V only meaningful for arithmetic ops.
   always_comb begin
      flags_d = flags_q;
      if ((state_q == EXECR || state_q == EXECI) && cond_ex && (s_bit || dp_cmp)) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ImmSrc     = op;
      RegSrc     = 2'b00;
      ALUControl = 3'b000;
      case (state_q)
         FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = u_bit ? 3'b000 : 3'b001;
            RegSrc     = 2'b10;
         end
         MEMRD:  AdrSrc = 1'b1;
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex;
            RegSrc   = 2'b10;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex;
         end
         EXECR:  ALUControl = alu_dp;
         EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_dp;
         end
         ALUWB: begin
            RegWrite = cond_ex & ~dp_nowrite;
            PCWrite  = cond_ex & ~dp_nowrite & (rd == 4'd15);
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            RegSrc    = 2'b01;
            PCWrite   = cond_ex;
         end
         default: ;
      endcase
      if (!reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb/tb_arm_mc_controller.sv - scoreboard bench for arm_mc_controller with directed instruction sequences
`timescale 1ns/1ps
module tb_arm_mc_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [2:0]  ALUControl;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [16:0] exp_q[$];
   string       nm_q[$];

   arm_mc_controller #(.COND_EN(1), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl}
   function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic asa, input logic [1:0] asb, input logic [1:0] imm,
                                     input logic [1:0] rsrc, input logic [2:0] alu);
      return {pcw, adr, mw, irw, rw, rs, asa, asb, imm, rsrc, alu};
   endfunction

   task automatic step(input string nm, input logic [16:0] e);
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fd(input string p, input logic [1:0] imm);
      step({p, "_fetch"},  v(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, imm, 2'b00, 3'b000));
      step({p, "_decode"}, v(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, imm, 2'b00, 3'b000));
   endtask

   task automatic branch(input string p, input logic [19:0] ins, input logic taken);
      Instr = ins;
      fd(p, 2'b10);
      step({p, "_branch"}, v(taken, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b10, 2'b01, 3'b000));
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [16:0] e, a;
         string       nm;
         e  = exp_q.pop_front();
         nm = nm_q.pop_front();
         a  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegSrc, ALUControl};
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL %s: got %b required %b", nm, a, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b0;
      Instr    = 20'h00000;
      ALUFlags = 4'b0000;
      @(posedge clk);
      #1;
      step("rst_hold", v(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000));
      reset = 1'b1;

      // flags are 0000 out of reset, so EQ fails
      branch("beq_z0", 20'h0A000, 1'b0);

      Instr = 20'hE0821;
      fd("add", 2'b00);
      step("add_execr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      step("add_aluwb", v(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));

      Instr = 20'hE2500;
      fd("subs", 2'b00);
      ALUFlags = 4'b0110;
      step("subs_execi", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 3'b001));
      ALUFlags = 4'b0000;
      step("subs_aluwb", v(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));

      branch("bne_z1", 20'h1AFFF, 1'b0);
      branch("beq_z1", 20'h0A000, 1'b1);

      Instr = 20'h10821;
      fd("addne", 2'b00);
      step("addne_execr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      step("addne_aluwb", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));

      Instr = 20'hE082F;
      fd("addpc", 2'b00);
      step("addpc_execr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      step("addpc_aluwb", v(1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));

      Instr = 20'hE3500;
      fd("cmp", 2'b00);
      ALUFlags = 4'b1000;
      step("cmp_execi", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 3'b001));
      ALUFlags = 4'b0000;
      step("cmp_aluwb", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000));

      branch("blt_n1", 20'hBA000, 1'b1);
      branch("bge_n1", 20'hAA000, 1'b0);
      branch("bmi_n1", 20'h4A000, 1'b1);

      Instr = 20'hEC000;
      fd("undef", 2'b11);

      Instr = 20'hE5154;
      fd("ldr", 2'b01);
      step("ldr_memadr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10, 3'b001));
      step("ldr_memrd",  v(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 3'b000));
      step("ldr_memwb",  v(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b01, 2'b00, 3'b000));

      Instr = 20'hE5854;
      fd("str", 2'b01);
      step("str_memadr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10, 3'b000));
      step("str_memwr",  v(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b10, 3'b000));

      Instr = 20'hF5854;
      fd("strnv", 2'b01);
      step("strnv_memadr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10, 3'b000));
      step("strnv_memwr",  v(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b10, 3'b000));

      Instr = 20'hE5854;
      fd("strrst", 2'b01);
      step("strrst_memadr", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10, 3'b000));
      reset = 1'b0;
      step("strrst_memwr", v(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b10, 3'b000));
      reset = 1'b1;

      // reset cleared N, so MI now fails
      branch("bmi_after_rst", 20'h4A000, 1'b0);

      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
